// File: rtl/ln_pkg.sv
// ----------------------------------------------------------------------------
// ln_pkg
// Shared definitions for the streaming natural-logarithm unit:
//   - ln_state_e   : controller states
//   - LN2_Q64      : ln(2) as a 64-bit binary fraction
//   - ln2_q()      : ln(2) truncated to a given number of fraction bits
//   - ln_lut_entry(): mantissa table entry ln(1 + k/2^addr_w), evaluated at
//                     elaboration from a 40-bit table fraction and then
//                     truncated to the requested output fraction width
// No ports (package).
// ----------------------------------------------------------------------------
package ln_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_SUM    = 3'd3,
        ST_OUT    = 3'd4
    } ln_state_e;

    localparam logic [63:0] LN2_Q64 = 64'hB172_17F7_D1CF_79AB;

    // Table precision and the wider guard precision used while building it.
    localparam int LUT_FRAC_W  = 40;
    localparam int LUT_GUARD_W = 56;

    // ln(2) truncated to frac_w fraction bits (frac_w <= 64).
    function automatic logic [63:0] ln2_q(input int frac_w);
        ln2_q = LN2_Q64 >> (64 - frac_w);
    endfunction

    // ln(1 + k/2^addr_w) via ln(y) = 2*atanh((y-1)/(y+1)); with y in [1,2)
    // the series argument is below 1/3, so 24 odd terms are far beyond the
    // guard precision. The final entry (k = 2^addr_w) is pinned to the same
    // truncated ln(2) the exponent path uses so both paths agree exactly.
    // Valid for frac_w <= 40.
    function automatic logic [63:0] ln_lut_entry(input int k, input int addr_w,
                                                 input int frac_w);
        logic [127:0] z;
        logic [127:0] z2;
        logic [127:0] term;
        logic [127:0] acc;
        logic [127:0] den;
        if (k == (32'sd1 << addr_w)) begin
            ln_lut_entry = ln2_q(frac_w);
        end else begin
            den  = (128'd1 << (addr_w + 1)) + 128'(k);
            z    = (128'(k) << LUT_GUARD_W) / den;
            z2   = (z * z) >> LUT_GUARD_W;
            term = z;
            acc  = 128'd0;
            for (int i = 0; i < 24; i++) begin
                acc  = acc + term / 128'(2 * i + 1);
                term = (term * z2) >> LUT_GUARD_W;
            end
            acc = (acc << 1) >> (LUT_GUARD_W - LUT_FRAC_W);
            ln_lut_entry = 64'(acc >> (LUT_FRAC_W - frac_w));
        end
    endfunction

endpackage

// File: rtl/ln_mant_lut.sv
// ----------------------------------------------------------------------------
// ln_mant_lut
// Registered dual-read ROM of ln(1 + k/2^LUT_ADDR_W), k = 0 .. 2^LUT_ADDR_W,
// in Q.OUT_FRAC_W. Returns entries a and a+1 one cycle after rd_en.
// Ports:
//   clock_i  in   clock
//   reset_i  in   synchronous active-high reset (clears read registers)
//   rd_en    in   capture a new pair of entries
//   addr     in   LUT_ADDR_W  table address a
//   lo_data  out  OUT_W       L[a]
//   hi_data  out  OUT_W       L[a+1]
// ----------------------------------------------------------------------------
module ln_mant_lut
    import ln_pkg::*;
#(
    parameter int LUT_ADDR_W = 8,
    parameter int OUT_W      = 32,
    parameter int OUT_FRAC_W = 26
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  rd_en,
    input  logic [LUT_ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]      lo_data,
    output logic [OUT_W-1:0]      hi_data
);

    localparam int DEPTH = (32'sd1 << LUT_ADDR_W) + 32'sd1;

    logic [OUT_W-1:0]    rom_s [DEPTH];
    logic [LUT_ADDR_W:0] idx_lo_s;
    logic [LUT_ADDR_W:0] idx_hi_s;
    logic [OUT_W-1:0]    lo_r;
    logic [OUT_W-1:0]    hi_r;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [OUT_W-1:0] ENTRY = OUT_W'(ln_lut_entry(k, LUT_ADDR_W, OUT_FRAC_W));
        assign rom_s[k] = ENTRY;
    end

    // The extra entry at 2^LUT_ADDR_W makes a+1 always in range.
    assign idx_lo_s = {1'b0, addr};
    assign idx_hi_s = idx_lo_s + {{LUT_ADDR_W{1'b0}}, 1'b1};

    // Read registers for the neighbouring entry pair.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lo_r <= '0;
            hi_r <= '0;
        end else if (rd_en) begin
            lo_r <= rom_s[idx_lo_s];
            hi_r <= rom_s[idx_hi_s];
        end else begin
            lo_r <= lo_r;
            hi_r <= hi_r;
        end
    end

    assign lo_data = lo_r;
    assign hi_data = hi_r;

endmodule

// File: rtl/ln_stream_unit.sv
// ----------------------------------------------------------------------------
// ln_stream_unit
// Handshaked fixed-point natural logarithm. Normalises x = 2^e * 1.m one bit
// per cycle, then forms e*ln2 + ln(1.m) from a mantissa table with optional
// linear interpolation. One operand in flight; zero operands raise out_err_o.
// Ports:
//   clock_i      in   clock
//   reset_i      in   synchronous active-high reset
//   in_data_i    in   DATA_W  unsigned Q(INT_W.FRAC_W) operand
//   in_valid_i   in   operand valid
//   in_ready_o   out  unit can accept an operand
//   out_data_o   out  OUT_W   signed Q(.OUT_FRAC_W) ln(x)
//   out_err_o    out  operand was zero (qualified by out_valid_o)
//   out_valid_o  out  result valid, held until accepted
//   out_ready_i  in   consumer accepts the result
// Requires LUT_ADDR_W + IP_W < DATA_W and OUT_FRAC_W <= 40.
// ----------------------------------------------------------------------------
module ln_stream_unit
    import ln_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 28,
    parameter int OUT_W      = 32,
    parameter int OUT_FRAC_W = 26,
    parameter int LUT_ADDR_W = 8,
    parameter int INTERP     = 0,
    parameter int IP_W       = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_err_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int INT_W = DATA_W - FRAC_W;
    localparam int EXP_W = $clog2(DATA_W) + 2;
    localparam int SUM_W = OUT_W + IP_W + 1;
    localparam logic signed [SUM_W-1:0] LN2_S = SUM_W'(ln2_q(OUT_FRAC_W));

    ln_state_e               state_r;
    ln_state_e               state_s;
    logic [DATA_W-1:0]       shift_r;
    logic signed [EXP_W-1:0] exp_r;
    logic                    zero_r;
    logic signed [SUM_W-1:0] e_ln2_r;
    logic [IP_W-1:0]         frac_r;
    logic [OUT_W-1:0]        out_data_r;
    logic                    out_err_r;
    logic                    out_valid_r;
    logic                    in_ready_r;
    logic [OUT_W-1:0]        lut_lo_s;
    logic [OUT_W-1:0]        lut_hi_s;
    logic signed [SUM_W-1:0] lo_ext_s;
    logic signed [SUM_W-1:0] hi_ext_s;
    logic signed [SUM_W-1:0] frac_ext_s;
    logic signed [SUM_W-1:0] interp_s;
    logic signed [SUM_W-1:0] sum_s;
    logic                    unused_s;

    ln_mant_lut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .OUT_W      (OUT_W),
        .OUT_FRAC_W (OUT_FRAC_W)
    ) u_lut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .rd_en   (state_r == ST_LOOKUP),
        .addr    (shift_r[DATA_W-2 -: LUT_ADDR_W]),
        .lo_data (lut_lo_s),
        .hi_data (lut_hi_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) state_s = ST_NORM;
                else            state_s = ST_IDLE;
            end
            ST_NORM: begin
                if (zero_r)                 state_s = ST_OUT;
                else if (shift_r[DATA_W-1]) state_s = ST_LOOKUP;
                else                        state_s = ST_NORM;
            end
            ST_LOOKUP: state_s = ST_SUM;
            ST_SUM:    state_s = ST_OUT;
            ST_OUT: begin
                if (out_ready_i) state_s = ST_IDLE;
                else             state_s = ST_OUT;
            end
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register; handshake flags are registered decodes of the next state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == ST_IDLE);
            out_valid_r <= (state_s == ST_OUT);
        end
    end

    // Normaliser: capture operand, then shift until the leading one reaches the MSB.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            shift_r <= '0;
            exp_r   <= '0;
            zero_r  <= 1'b0;
        end else if (state_r == ST_IDLE && in_valid_i) begin
            shift_r <= in_data_i;
            exp_r   <= EXP_W'(INT_W - 32'sd1);
            zero_r  <= (in_data_i == '0);
        end else if (state_r == ST_NORM && !zero_r && !shift_r[DATA_W-1]) begin
            shift_r <= {shift_r[DATA_W-2:0], 1'b0};
            exp_r   <= exp_r - EXP_W'(32'sd1);
        end else begin
            shift_r <= shift_r;
            exp_r   <= exp_r;
            zero_r  <= zero_r;
        end
    end

    // Exponent term and interpolation fraction, captured alongside the table read.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            e_ln2_r <= '0;
            frac_r  <= '0;
        end else if (state_r == ST_LOOKUP) begin
            e_ln2_r <= SUM_W'(exp_r) * LN2_S;
            frac_r  <= shift_r[DATA_W-2-LUT_ADDR_W -: IP_W];
        end else begin
            e_ln2_r <= e_ln2_r;
            frac_r  <= frac_r;
        end
    end

    // Final sum; table entries are non-negative so they zero-extend, and the
    // arithmetic shift floors the interpolation term.
    always_comb begin
        lo_ext_s   = SUM_W'(lut_lo_s);
        hi_ext_s   = SUM_W'(lut_hi_s);
        frac_ext_s = SUM_W'(frac_r);
        if (INTERP != 0) begin
            interp_s = ((hi_ext_s - lo_ext_s) * frac_ext_s) >>> IP_W;
        end else begin
            interp_s = '0;
        end
        sum_s = e_ln2_r + lo_ext_s + interp_s;
    end

    // Guard bits above OUT_W are provably zero/sign copies for legal ranges.
    assign unused_s = ^sum_s[SUM_W-1:OUT_W];

    // Result registers, held stable while the result waits in ST_OUT.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_data_r <= '0;
            out_err_r  <= 1'b0;
        end else if (state_r == ST_NORM && zero_r) begin
            out_data_r <= {1'b1, {(OUT_W-1){1'b0}}};
            out_err_r  <= 1'b1;
        end else if (state_r == ST_SUM) begin
            out_data_r <= sum_s[OUT_W-1:0];
            out_err_r  <= 1'b0;
        end else begin
            out_data_r <= out_data_r;
            out_err_r  <= out_err_r;
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_err_o   = out_err_r;

endmodule

// File: tb/tb_ln_stream_unit.sv
module tb_ln_stream_unit;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [31:0] out_data_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_data;
    logic [31:0] got_data_b;
    logic        got_err;
    int          got_lat;

    always #5 clock_i = ~clock_i;

    // Default configuration: table only, 8 address bits.
    ln_stream_unit dut_a (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_a),
        .out_data_o  (out_data_a),
        .out_err_o   (out_err_a),
        .out_valid_o (out_valid_a),
        .out_ready_i (out_ready)
    );

    // Interpolating configuration with a 6-bit table, driven in lockstep.
    ln_stream_unit #(.LUT_ADDR_W(6), .INTERP(1)) dut_b (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_b),
        .out_data_o  (out_data_b),
        .out_err_o   (out_err_b),
        .out_valid_o (out_valid_b),
        .out_ready_i (out_ready)
    );

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    // Present one operand for one cycle, wait for the result, then take it
    // (if out_ready is high). got_lat = n means valid first seen in cycle T+n.
    task automatic send_op(input logic [31:0] op);
        in_data  = op;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got_lat  = 1;
        while (!out_valid_a && got_lat < 200) begin
            step();
            got_lat++;
        end
        got_data   = out_data_a;
        got_data_b = out_data_b;
        got_err    = out_err_a;
        if (out_ready) step();
    endtask

    task automatic test_reset();
        reset_i   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1000_0000;
        out_ready = 1'b1;
        repeat (3) step();
        reset_i  = 1'b0;
        in_valid = 1'b0;
        step();
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_a); end
        total++; if (out_data_a !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data_a); end
        total++; if (out_err_a !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err_a); end
        repeat (10) step();
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_ignored_valid got=%b want=0", out_valid_a); end
    endtask

    // Directed operands with hand-derived results (LN2 = 0x02C5C85F in Q.26).
    task automatic test_directed();
        logic [31:0] ops  [5] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h0800_0000, 32'h0000_0001};
        logic [31:0] exps [5] = '{32'h0000_0000, 32'h02C5_C85F, 32'h0464_FA9D, 32'hFD3A_37A1, 32'hB25E_159C};
        int          lats [5] = '{7, 6, 6, 8, 35};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_op(ops[i]);
            total++; if (got_data !== exps[i]) begin bad++; $display("FAIL directed_data op=%h got=%h want=%h", ops[i], got_data, exps[i]); end
            total++; if (got_err !== 1'b0) begin bad++; $display("FAIL directed_err op=%h got=%b want=0", ops[i], got_err); end
            total++; if (got_lat != lats[i]) begin bad++; $display("FAIL directed_latency op=%h got=T+%0d want=T+%0d", ops[i], got_lat, lats[i]); end
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send_op(32'h0000_0000);
        total++; if (got_data !== 32'h8000_0000) begin bad++; $display("FAIL zero_data got=%h want=80000000", got_data); end
        total++; if (got_err !== 1'b1) begin bad++; $display("FAIL zero_err got=%b want=1", got_err); end
        total++; if (got_lat != 2) begin bad++; $display("FAIL zero_latency got=T+%0d want=T+2", got_lat); end
        send_op(32'h1000_0000);
        total++; if (got_data !== 32'h0) begin bad++; $display("FAIL after_zero_data got=%h want=00000000", got_data); end
        total++; if (got_err !== 1'b0) begin bad++; $display("FAIL after_zero_err got=%b want=0", got_err); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        in_data   = 32'h2000_0000;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 200) begin
            step();
            lat++;
        end
        total++; if (lat != 6) begin bad++; $display("FAIL bp_latency got=T+%0d want=T+6", lat); end
        in_data  = 32'h0000_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'h02C5_C85F || in_ready_a !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%h ready=%b want valid=1 data=02c5c85f ready=0",
                         i, out_valid_a, out_data_a, in_ready_a);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready_a); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid_a); end
        repeat (5) step();
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_not_captured got=%b want=0", out_valid_a); end
    endtask

    task automatic test_reset_in_norm();
        logic seen;
        out_ready = 1'b1;
        in_data   = 32'h0000_0001;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_norm_valid got=%b want=0", out_valid_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_norm_ready got=%b want=1", in_ready_a); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid_a) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_norm_dropped got=%b want=0", seen); end
        send_op(32'h2000_0000);
        total++; if (got_data !== 32'h02C5_C85F) begin bad++; $display("FAIL rst_norm_resume got=%h want=02c5c85f", got_data); end
    endtask

    // Operands carry at most 14 significant bits below the leading one, so
    // the interpolating unit sees every bit and its error is only the
    // interpolation curvature plus rounding.
    task automatic test_accuracy();
        int          k;
        int          r;
        logic [31:0] op;
        real         want;
        real         err_a;
        real         err_b;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            k  = $urandom_range(0, 17);
            r  = $urandom_range(0, 16383);
            op = (32'h0000_4000 | 32'(r)) << (17 - k);
            send_op(op);
            want  = $ln(real'(op) / 268435456.0);
            err_a = real'($signed(got_data)) / 67108864.0 - want;
            err_b = real'($signed(got_data_b)) / 67108864.0 - want;
            if (err_a < 0.0) err_a = -err_a;
            if (err_b < 0.0) err_b = -err_b;
            total++; if (err_b > 1.0 / 16384.0) begin bad++; $display("FAIL interp_accuracy op=%h got=%h err=%e want_err<=%e", op, got_data_b, err_b, 1.0 / 16384.0); end
            total++; if (err_a > 1.0 / 128.0) begin bad++; $display("FAIL table_accuracy op=%h got=%h err=%e want_err<=%e", op, got_data, err_a, 1.0 / 128.0); end
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        test_reset();
        test_directed();
        test_zero();
        test_backpressure();
        test_reset_in_norm();
        test_accuracy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
